mips_control_fsm: RTL and testbench
===================================

// Module: mips_control_fsm
// PURPOSE
//  Multi-cycle main controller for the non-pipelined MIPS core. Sequences FETCH..JUMP states of
//  mips_state_e from the IR opcode/funct fields. Drives datapath mux selects, register/memory/IR/PC
//  write enables and a 2-bit ALU-op class for the downstream ALU decoder. Sits between IR and datapath.
// PARAMETERS
//  RA_REG   5'd31  destination register index written by JAL
// PORTS
//  clk          in   1  core clock, all state on rising edge
//  rst          in   1  asynchronous reset, active-high
//  en           in   1  advance enable; 0 freezes state (stall), all write enables forced 0
//  op           in   6  mips_op_e, IR[31:26]; valid from DECODE onward
//  funct        in   6  mips_funct_e, IR[5:0]
//  zero         in   1  ALU zero flag, sampled in BRANCH
//  state        out  4  current mips_state_e
//  ir_write     out  1  load IR from memory read data
//  iord         out  1  0: mem addr=PC, 1: mem addr=ALUOut
//  mem_write    out  1  memory write strobe
//  mem_size     out  2  00 word, 01 half, 10 byte (load zero-extends)
//  reg_write    out  1  register file write enable
//  reg_dst      out  2  00 rt, 01 rd, 10 RA_REG
//  mem_to_reg   out  2  00 ALUOut, 01 MDR, 10 PC
//  alu_src_a    out  1  0 PC, 1 reg A
//  alu_src_b    out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op       out  2  00 add, 01 sub, 10 decode funct, 11 decode op (I-type ALU)
//  pc_src       out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],jump,2'b0}, 11 reg A
//  pc_en        out  1  PC load = pc_write | (beq & zero) | (bne & ~zero), gated by en
//  illegal_op   out  1  one-cycle pulse in DECODE for unsupported op/funct
// BEHAVIOUR
//  Reset: state=FETCH; every output 0 except values implied by FETCH decode (see below) once rst drops.
//  While rst high: all write enables, pc_en, illegal_op = 0. Reset mid-instruction aborts it, no partial write.
//  Outputs Moore-decoded from registered state (+op/funct for JUMP/BRANCH/size); no output depends on zero
//  except pc_en in BRANCH. Unlisted outputs 0 in each state.
//  FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_write=1 -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next:
//   LW/LBU/LHU/LL/SW/SH/SB -> MEMADDR; RTYPE & funct!=JR -> EXECUTE; RTYPE & JR -> JUMP;
//   BEQ/BNE -> BRANCH; ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/LUI -> ADDIEXECUTE; J/JAL -> JUMP;
//   SC, unknown op, unknown R funct -> FETCH with illegal_op=1 (instruction is a no-op).
//  MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEMREAD for loads, MEMWRITE for stores.
//  MEMREAD: iord=1, mem_size by op -> MEMWRITEBACK.  MEMWRITEBACK: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
//  MEMWRITE: iord=1, mem_write=1, mem_size by op -> FETCH. LL is treated exactly as LW.
//  EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWRITEBACK (reg_write, reg_dst=01, mem_to_reg=00) -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; pc_en per op/zero -> FETCH.
//  ADDIEXECUTE: alu_src_a=1, alu_src_b=10, alu_op=11 -> ADDIWRITEBACK (reg_write, reg_dst=00, mem_to_reg=00) -> FETCH.
//  JUMP: pc_en=1; J/JAL pc_src=10, JR pc_src=11; JAL also reg_write=1, reg_dst=10, mem_to_reg=10
//   (PC already PC+4 from FETCH) -> FETCH.
//  Latency in enabled cycles: J/JAL/JR/BEQ/BNE 3; R-type, I-ALU, stores 4; loads 5.
//  en=0: state holds, mux selects hold current-state values, ir_write/mem_write/reg_write/pc_en/illegal_op=0.
//  Unencoded state values 12-15: recover to FETCH next cycle, no writes asserted.
// TESTING
//  rst pulse mid-MEMWRITE -> state=FETCH immediately (async), mem_write=0 during and after reset.
//  LW (op=0x23) -> FETCH,DECODE,MEMADDR,MEMREAD,MEMWRITEBACK; reg_write=1 only in cycle 5, mem_to_reg=01.
//  BEQ zero=1 then BNE zero=1 -> pc_en=1 in BRANCH for BEQ, pc_en=0 for BNE; both return to FETCH.
//  JAL (op=0x03) -> JUMP with pc_src=10, reg_write=1, reg_dst=10; JR (funct=0x08) -> pc_src=11, reg_write=0.
//  op=0x38 (SC) or RTYPE funct=0x3F -> illegal_op=1 one cycle in DECODE, next state FETCH, no writes.
//  ADDI with en=0 for 3 cycles in ADDIEXECUTE -> state held, reg_write stays 0 until en=1 then ADDIWRITEBACK.

Source files
------------

// File: rtl/mips_control_fsm.sv
// Multi-cycle main controller for the non-pipelined MIPS core: sequences FETCH..JUMP from the
// IR opcode/funct and drives datapath mux selects, write enables and the ALU-op class.
module mips_control_fsm #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    output logic [3:0] o_state,
    output logic       o_ir_write,
    output logic       o_iord,
    output logic       o_mem_write,
    output logic [1:0] o_mem_size,
    output logic       o_reg_write,
    output logic [1:0] o_reg_dst,
    output logic [1:0] o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_src,
    output logic       o_pc_en,
    output logic       o_illegal_op
);

    typedef enum logic [3:0] {
        FETCH         = 4'd0,
        DECODE        = 4'd1,
        MEMADDR       = 4'd2,
        MEMREAD       = 4'd3,
        MEMWRITEBACK  = 4'd4,
        MEMWRITE      = 4'd5,
        EXECUTE       = 4'd6,
        ALUWRITEBACK  = 4'd7,
        BRANCH        = 4'd8,
        ADDIEXECUTE   = 4'd9,
        ADDIWRITEBACK = 4'd10,
        JUMP          = 4'd11
    } mips_state_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B,
        OP_LL    = 6'h30,
        OP_SC    = 6'h38
    } mips_op_e;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_SRA  = 6'h03,
        F_SLLV = 6'h04,
        F_SRLV = 6'h06,
        F_SRAV = 6'h07,
        F_JR   = 6'h08,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2A,
        F_SLTU = 6'h2B
    } mips_funct_e;

    // The link register is hard-wired in the datapath through reg_dst=10; r0 would discard the link.
    generate
        if (RA_REG == 5'd0) begin : g_ra_check
            $error("RA_REG must not select r0");
        end
    endgenerate

    mips_state_e r_state;
    mips_state_e w_state_next;

    logic w_funct_ok;
    logic w_is_load;
    logic w_is_store;
    logic w_is_rtype;
    logic w_is_jr;
    logic w_is_branch;
    logic w_is_ialu;
    logic w_is_jump;
    logic w_is_legal;
    logic [1:0] w_mem_size;
    logic w_go;

    assign w_go = i_en & ~i_rst;

    always_comb begin
        w_funct_ok = 1'b0;
        case (i_funct)
            F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
            F_XOR, F_NOR, F_SLT, F_SLTU: w_funct_ok = 1'b1;
            default:                     w_funct_ok = 1'b0;
        endcase
    end

    // Instruction class from the opcode; SC is deliberately left unclassified so it decodes illegal.
    always_comb begin
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_rtype  = 1'b0;
        w_is_jr     = 1'b0;
        w_is_branch = 1'b0;
        w_is_ialu   = 1'b0;
        w_is_jump   = 1'b0;
        case (i_op)
            OP_LW, OP_LBU, OP_LHU, OP_LL: w_is_load = 1'b1;
            OP_SW, OP_SH, OP_SB:          w_is_store = 1'b1;
            OP_RTYPE: begin
                if (i_funct == F_JR) begin
                    w_is_jr = 1'b1;
                end else begin
                    w_is_rtype = w_funct_ok;
                end
            end
            OP_BEQ, OP_BNE:               w_is_branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_LUI:      w_is_ialu = 1'b1;
            OP_J, OP_JAL:                 w_is_jump = 1'b1;
            default: ;
        endcase
    end

    assign w_is_legal = w_is_load | w_is_store | w_is_rtype | w_is_jr |
                        w_is_branch | w_is_ialu | w_is_jump;

    always_comb begin
        w_mem_size = 2'b00;
        case (i_op)
            OP_LHU, OP_SH: w_mem_size = 2'b01;
            OP_LBU, OP_SB: w_mem_size = 2'b10;
            default:       w_mem_size = 2'b00;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:         if (i_en) w_state_next = DECODE;
            DECODE: begin
                if (i_en) begin
                    if (w_is_load | w_is_store)   w_state_next = MEMADDR;
                    else if (w_is_rtype)          w_state_next = EXECUTE;
                    else if (w_is_jr | w_is_jump) w_state_next = JUMP;
                    else if (w_is_branch)         w_state_next = BRANCH;
                    else if (w_is_ialu)           w_state_next = ADDIEXECUTE;
                    else                          w_state_next = FETCH;
                end
            end
            MEMADDR:       if (i_en) w_state_next = w_is_store ? MEMWRITE : MEMREAD;
            MEMREAD:       if (i_en) w_state_next = MEMWRITEBACK;
            MEMWRITEBACK:  if (i_en) w_state_next = FETCH;
            MEMWRITE:      if (i_en) w_state_next = FETCH;
            EXECUTE:       if (i_en) w_state_next = ALUWRITEBACK;
            ALUWRITEBACK:  if (i_en) w_state_next = FETCH;
            BRANCH:        if (i_en) w_state_next = FETCH;
            ADDIEXECUTE:   if (i_en) w_state_next = ADDIWRITEBACK;
            ADDIWRITEBACK: if (i_en) w_state_next = FETCH;
            JUMP:          if (i_en) w_state_next = FETCH;
            // Unencoded codes recover even while stalled so a corrupted register cannot hang the core.
            default:       w_state_next = FETCH;
        endcase
    end

    logic w_ir_write;
    logic w_mem_write;
    logic w_reg_write;
    logic w_pc_write;
    logic w_branch_take;
    logic w_illegal;

    always_comb begin
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_pc_write    = 1'b0;
        w_branch_take = 1'b0;
        w_illegal     = 1'b0;
        o_iord        = 1'b0;
        o_mem_size    = 2'b00;
        o_reg_dst     = 2'b00;
        o_mem_to_reg  = 2'b00;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 2'b00;
        o_alu_op      = 2'b00;
        o_pc_src      = 2'b00;
        if (!i_rst) begin
            case (r_state)
                FETCH: begin
                    w_ir_write  = 1'b1;
                    o_alu_src_b = 2'b01;
                    w_pc_write  = 1'b1;
                end
                DECODE: begin
                    o_alu_src_b = 2'b11;
                    w_illegal   = ~w_is_legal;
                end
                MEMADDR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                end
                MEMREAD: begin
                    o_iord     = 1'b1;
                    o_mem_size = w_mem_size;
                end
                MEMWRITEBACK: begin
                    w_reg_write  = 1'b1;
                    o_mem_to_reg = 2'b01;
                end
                MEMWRITE: begin
                    o_iord      = 1'b1;
                    w_mem_write = 1'b1;
                    o_mem_size  = w_mem_size;
                end
                EXECUTE: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = 2'b10;
                end
                ALUWRITEBACK: begin
                    w_reg_write = 1'b1;
                    o_reg_dst   = 2'b01;
                end
                BRANCH: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_op      = 2'b01;
                    o_pc_src      = 2'b01;
                    w_branch_take = ((i_op == OP_BEQ) & i_zero) | ((i_op == OP_BNE) & ~i_zero);
                end
                ADDIEXECUTE: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                    o_alu_op    = 2'b11;
                end
                ADDIWRITEBACK: begin
                    w_reg_write = 1'b1;
                end
                JUMP: begin
                    w_pc_write = 1'b1;
                    o_pc_src   = (i_op == OP_RTYPE) ? 2'b11 : 2'b10;
                    // PC already holds PC+4 from FETCH, which is the link value for JAL.
                    if (i_op == OP_JAL) begin
                        w_reg_write  = 1'b1;
                        o_reg_dst    = 2'b10;
                        o_mem_to_reg = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_ir_write   = w_ir_write & w_go;
    assign o_mem_write  = w_mem_write & w_go;
    assign o_reg_write  = w_reg_write & w_go;
    assign o_pc_en      = (w_pc_write | w_branch_take) & w_go;
    assign o_illegal_op = w_illegal & w_go;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Randomised scoreboard bench for mips_control_fsm: a driver plans each instruction's cycle
// sequence from the ISA rules and queues expectations; a negedge monitor pops and compares them.
module tb_mips_control_fsm;

    logic       i_clk;
    logic       i_rst;
    logic       i_en;
    logic [5:0] i_op;
    logic [5:0] i_funct;
    logic       i_zero;
    logic [3:0] o_state;
    logic       o_ir_write;
    logic       o_iord;
    logic       o_mem_write;
    logic [1:0] o_mem_size;
    logic       o_reg_write;
    logic [1:0] o_reg_dst;
    logic [1:0] o_mem_to_reg;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_alu_op;
    logic [1:0] o_pc_src;
    logic       o_pc_en;
    logic       o_illegal_op;

    mips_control_fsm #(.RA_REG(5'd31)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_op(i_op), .i_funct(i_funct), .i_zero(i_zero),
        .o_state(o_state), .o_ir_write(o_ir_write), .o_iord(o_iord), .o_mem_write(o_mem_write),
        .o_mem_size(o_mem_size), .o_reg_write(o_reg_write), .o_reg_dst(o_reg_dst),
        .o_mem_to_reg(o_mem_to_reg), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_alu_op(o_alu_op), .o_pc_src(o_pc_src), .o_pc_en(o_pc_en), .o_illegal_op(o_illegal_op)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
    } rec_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        rec_t       r;
    } sb_t;

    rec_t w_got;
    assign w_got = {o_state, o_ir_write, o_iord, o_mem_write, o_mem_size, o_reg_write, o_reg_dst,
                    o_mem_to_reg, o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_src, o_pc_en, o_illegal_op};

    int   total = 0;
    int   bad   = 0;
    sb_t  exp_q[$];
    rec_t plan[$];

    localparam int C_LOAD = 0, C_STORE = 1, C_RTYPE = 2, C_JR = 3, C_BRANCH = 4,
                   C_IALU = 5, C_JUMP = 6, C_ILL = 7;

    logic [5:0] op_pool [0:23] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                   6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h24,
                                   6'h25, 6'h28, 6'h29, 6'h2B, 6'h30, 6'h38, 6'h3F, 6'h11};
    logic [5:0] funct_pool [0:19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20,
                                      6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                      6'h2B, 6'h3F, 6'h01, 6'h18};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input rec_t got, input rec_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h (state %0d) required=%h (state %0d)",
                     name, $time, got, got.state, exp, exp.state);
        end
    endtask

    function automatic int cls(input logic [5:0] op, input logic [5:0] funct);
        if (op inside {6'h23, 6'h24, 6'h25, 6'h30}) return C_LOAD;
        if (op inside {6'h2B, 6'h29, 6'h28}) return C_STORE;
        if (op == 6'h00) begin
            if (funct == 6'h08) return C_JR;
            if (funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B})
                return C_RTYPE;
            return C_ILL;
        end
        if (op inside {6'h04, 6'h05}) return C_BRANCH;
        if (op inside {[6'h08:6'h0D], 6'h0F}) return C_IALU;
        if (op inside {6'h02, 6'h03}) return C_JUMP;
        return C_ILL;
    endfunction

    function automatic logic [1:0] size_of(input logic [5:0] op);
        if (op == 6'h25 || op == 6'h29) return 2'b01;
        if (op == 6'h24 || op == 6'h28) return 2'b10;
        return 2'b00;
    endfunction

    // Whole-instruction cycle plan (all cycles enabled); branch pc_en is fixed up per cycle by the driver.
    task automatic plan_instr(input logic [5:0] op, input logic [5:0] funct);
        rec_t r;
        int   c;
        c = cls(op, funct);
        plan.delete();
        r = '0; r.state = 4'd0; r.ir_write = 1'b1; r.alu_src_b = 2'b01; r.pc_en = 1'b1; plan.push_back(r);
        r = '0; r.state = 4'd1; r.alu_src_b = 2'b11; r.illegal_op = (c == C_ILL); plan.push_back(r);
        if (c == C_LOAD || c == C_STORE) begin
            r = '0; r.state = 4'd2; r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; plan.push_back(r);
        end
        case (c)
            C_LOAD: begin
                r = '0; r.state = 4'd3; r.iord = 1'b1; r.mem_size = size_of(op); plan.push_back(r);
                r = '0; r.state = 4'd4; r.reg_write = 1'b1; r.mem_to_reg = 2'b01; plan.push_back(r);
            end
            C_STORE: begin
                r = '0; r.state = 4'd5; r.iord = 1'b1; r.mem_write = 1'b1; r.mem_size = size_of(op);
                plan.push_back(r);
            end
            C_RTYPE: begin
                r = '0; r.state = 4'd6; r.alu_src_a = 1'b1; r.alu_op = 2'b10; plan.push_back(r);
                r = '0; r.state = 4'd7; r.reg_write = 1'b1; r.reg_dst = 2'b01; plan.push_back(r);
            end
            C_JR: begin
                r = '0; r.state = 4'd11; r.pc_en = 1'b1; r.pc_src = 2'b11; plan.push_back(r);
            end
            C_BRANCH: begin
                r = '0; r.state = 4'd8; r.alu_src_a = 1'b1; r.alu_op = 2'b01; r.pc_src = 2'b01;
                plan.push_back(r);
            end
            C_IALU: begin
                r = '0; r.state = 4'd9; r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.alu_op = 2'b11;
                plan.push_back(r);
                r = '0; r.state = 4'd10; r.reg_write = 1'b1; plan.push_back(r);
            end
            C_JUMP: begin
                r = '0; r.state = 4'd11; r.pc_en = 1'b1; r.pc_src = 2'b10;
                if (op == 6'h03) begin
                    r.reg_write = 1'b1; r.reg_dst = 2'b10; r.mem_to_reg = 2'b10;
                end
                plan.push_back(r);
            end
            default: ;
        endcase
    endtask

    // zmode: 0/1 hold zero at that value, 2 randomise it every cycle. Called at posedge+1 in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int zmode,
                             input int stall_k, input int stall_n, input bit rnd);
        int   ns;
        logic z;
        rec_t e;
        sb_t  s;
        plan_instr(op, funct);
        i_op = op;
        i_funct = funct;
        for (int k = 0; k < plan.size(); k++) begin
            ns = (k == stall_k) ? stall_n : 0;
            if (rnd && $urandom_range(0, 3) == 0) ns = $urandom_range(1, 2);
            for (int st = 0; st <= ns; st++) begin
                z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
                i_zero = z;
                i_en = (st == ns);
                e = plan[k];
                if (e.state == 4'd8) e.pc_en = (op == 6'h04) ? z : !z;
                if (!i_en) begin
                    e.ir_write = 1'b0; e.mem_write = 1'b0; e.reg_write = 1'b0;
                    e.pc_en = 1'b0; e.illegal_op = 1'b0;
                end
                s.op = op; s.funct = funct; s.r = e;
                exp_q.push_back(s);
                @(posedge i_clk); #1;
            end
        end
    endtask

    initial begin : monitor
        sb_t s;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() != 0) begin
                s = exp_q.pop_front();
                check($sformatf("sb op=%02h funct=%02h", s.op, s.funct), w_got, s.r);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [5:0] op;
        logic [5:0] funct;
        i_rst = 1'b1; i_en = 1'b1; i_op = 6'h00; i_funct = 6'h00; i_zero = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_outputs", w_got, '0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        run_instr(6'h23, 6'h00, 0, -1, 0, 1'b0);   // LW

        // SW interrupted by an asynchronous reset while in MEMWRITE
        i_op = 6'h2B; i_funct = 6'h00; i_en = 1'b1; i_zero = 1'b0;
        repeat (3) begin
            @(posedge i_clk); #1;
        end
        check("sw_in_memwrite", {o_state, o_mem_write}, {4'd5, 1'b1});
        #2 i_rst = 1'b1;
        #1 check("async_rst_abort", w_got, '0);
        @(posedge i_clk); #1;
        check("rst_held", w_got, '0);
        i_rst = 1'b0;

        run_instr(6'h04, 6'h00, 1, -1, 0, 1'b0);   // BEQ taken
        run_instr(6'h05, 6'h00, 1, -1, 0, 1'b0);   // BNE not taken
        run_instr(6'h03, 6'h00, 0, -1, 0, 1'b0);   // JAL
        run_instr(6'h00, 6'h08, 0, -1, 0, 1'b0);   // JR
        run_instr(6'h38, 6'h00, 0, -1, 0, 1'b0);   // SC -> illegal
        run_instr(6'h00, 6'h3F, 0, -1, 0, 1'b0);   // bad funct -> illegal
        run_instr(6'h08, 6'h00, 0, 2, 3, 1'b0);    // ADDI stalled 3 cycles in ADDIEXECUTE
        run_instr(6'h00, 6'h20, 0, 1, 2, 1'b0);    // ADD stalled in DECODE

        for (int n = 0; n < 200; n++) begin
            op = op_pool[$urandom_range(0, 23)];
            funct = funct_pool[$urandom_range(0, 19)];
            run_instr(op, funct, 2, -1, 0, 1'b1);
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge i_clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
